instr_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute/writeback control unit for the 8-register, 16-bit processor.
- Fetches instruction words over a request/valid handshake and decodes them.
- Drives the register file's control side: source/destination indices, write strobe, move-immediate strobes, immediate byte and register-file clock enable. Also drives ALU op select and data-memory read/write handshakes.
- Sits between instruction memory and the register-file/ALU datapath.

---
 rtl/instr_sequencer_pkg.sv | 42 ++++
 rtl/instr_sequencer.sv | 115 +++++++++++
 tb/tb_instr_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states and
// instruction-register field positions.
package instr_sequencer_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_ADDC  = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_SUBB  = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_NOT   = 4'h8;
    localparam logic [3:0] OP_SHL   = 4'h9;
    localparam logic [3:0] OP_SHR   = 4'hA;
    localparam logic [3:0] OP_MOVIL = 4'hB;
    localparam logic [3:0] OP_MOVIH = 4'hC;
    localparam logic [3:0] OP_LOAD  = 4'hD;
    localparam logic [3:0] OP_STORE = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALTED
    } state_t;

    localparam int IR_OP_LSB   = 12;
    localparam int IR_DST_LSB  = 9;
    localparam int IR_SRC1_LSB = 6;
    localparam int IR_SRC2_LSB = 3;
    localparam int IR_IMM_LSB  = 0;

    // ALU results and loads land in the destination register via the write strobe.
    function automatic logic writes_dest(input logic [3:0] op);
        return ((op >= OP_ADD) && (op <= OP_SHR)) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback control unit driving the
// register-file control side, ALU op select and data-memory handshakes.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk_pi,
    input  logic            reset_n_pi,
    input  logic            clk_en_pi,
    input  logic [15:0]     imem_data_pi,
    input  logic            imem_valid_pi,
    output logic            imem_req_po,
    output logic [PC_W-1:0] pc_po,
    input  logic            dmem_valid_pi,
    output logic            dmem_rd_po,
    output logic            dmem_wr_po,
    output logic [2:0]      source_reg1_po,
    output logic [2:0]      source_reg2_po,
    output logic [2:0]      destination_reg_po,
    output logic            wr_destination_reg_po,
    output logic            movi_lower_po,
    output logic            movi_higher_po,
    output logic [7:0]      immediate_po,
    output logic            regfile_clk_en_po,
    output logic [3:0]      alu_op_po,
    output logic            halted_po
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q;
    logic [15:0]     ir_q;
    logic [3:0]      opcode;

    assign opcode             = ir_q[IR_OP_LSB +: 4];
    assign alu_op_po          = opcode;
    assign destination_reg_po = ir_q[IR_DST_LSB +: 3];
    assign source_reg1_po     = ir_q[IR_SRC1_LSB +: 3];
    assign source_reg2_po     = ir_q[IR_SRC2_LSB +: 3];
    assign immediate_po       = ir_q[IR_IMM_LSB +: 8];
    assign pc_po              = pc_q;

    // Everything freezes while clk_en_pi is low, so Moore strobes simply persist.
    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else if (clk_en_pi) begin
            state_q <= state_d;
            if ((state_q == FETCH) && imem_valid_pi) begin
                ir_q <= imem_data_pi;
            end
            if (state_q == WB) begin
                pc_q <= pc_q + PC_W'(1);
            end
        end
    end

    always_comb begin
        state_d               = state_q;
        imem_req_po           = 1'b0;
        dmem_rd_po            = 1'b0;
        dmem_wr_po            = 1'b0;
        wr_destination_reg_po = 1'b0;
        movi_lower_po         = 1'b0;
        movi_higher_po        = 1'b0;
        regfile_clk_en_po     = 1'b0;
        halted_po             = 1'b0;
        unique case (state_q)
            FETCH: begin
                imem_req_po = 1'b1;
                if (imem_valid_pi) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (opcode == OP_HALT) begin
                    state_d = HALTED;
                end else if (opcode == OP_NOP) begin
                    state_d = WB;
                end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
                    state_d = MEM;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = WB;
            end
            MEM: begin
                dmem_rd_po = (opcode == OP_LOAD);
                dmem_wr_po = (opcode == OP_STORE);
                if (dmem_valid_pi) begin
                    state_d = WB;
                end
            end
            WB: begin
                wr_destination_reg_po = writes_dest(opcode);
                movi_lower_po         = (opcode == OP_MOVIL);
                movi_higher_po        = (opcode == OP_MOVIH);
                regfile_clk_en_po     = writes_dest(opcode) || (opcode == OP_MOVIL)
                                        || (opcode == OP_MOVIH);
                state_d               = FETCH;
            end
            HALTED: begin
                halted_po = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized
// instruction streams checked against a per-instruction timing/strobe model.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_en = 1'b1;
    logic [15:0] imem_data = 16'h0;
    logic        imem_valid = 1'b0;
    logic        dmem_valid = 1'b0;
    logic        imem_req;
    logic [7:0]  pc;
    logic        dmem_rd, dmem_wr;
    logic [2:0]  src1, src2, dst;
    logic        wr_dst, movil, movih, rf_en, halted;
    logic [7:0]  imm;
    logic [3:0]  alu_op;

    int passed = 0;
    int total  = 0;
    int pc_m   = 0;

    instr_sequencer #(.PC_W(8)) dut (
        .clk_pi(clk), .reset_n_pi(reset_n), .clk_en_pi(clk_en),
        .imem_data_pi(imem_data), .imem_valid_pi(imem_valid), .imem_req_po(imem_req),
        .pc_po(pc), .dmem_valid_pi(dmem_valid), .dmem_rd_po(dmem_rd), .dmem_wr_po(dmem_wr),
        .source_reg1_po(src1), .source_reg2_po(src2), .destination_reg_po(dst),
        .wr_destination_reg_po(wr_dst), .movi_lower_po(movil), .movi_higher_po(movih),
        .immediate_po(imm), .regfile_clk_en_po(rf_en), .alu_op_po(alu_op), .halted_po(halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting in a fetch cycle; returns at the next fetch
    // (or once halted) and checks duration, strobe counts and field stability.
    task automatic run_instr(input logic [15:0] word, input int fwait, input int mwait,
                             input bit noise);
        int fc = 0, mc = 0, total_c = 0;
        int wr_n = 0, rf_n = 0, ml_n = 0, mh_n = 0, rd_n = 0, st_n = 0, rf_cyc = -1;
        int exp_total, exp_rf_cyc;
        bit seen_nf = 0, done = 0, field_bad = 0;
        logic [3:0] op;
        bit is_alu, is_mem, exp_wr, exp_rf;
        op     = word[15:12];
        is_alu = (op >= 4'h1) && (op <= 4'hC);
        is_mem = (op == 4'hD) || (op == 4'hE);
        exp_wr = ((op >= 4'h1) && (op <= 4'hA)) || (op == 4'hD);
        exp_rf = exp_wr || (op == 4'hB) || (op == 4'hC);
        if (op == 4'hF) exp_total = fwait + 2;
        else exp_total = fwait + 3 + (is_alu ? 1 : 0) + (is_mem ? mwait + 1 : 0);
        exp_rf_cyc = exp_rf ? exp_total : -1;

        for (int cyc = 1; cyc <= 80; cyc++) begin
            if ((imem_req && seen_nf) || halted) begin
                done = 1;
                total_c = cyc - 1;
                break;
            end
            if (!imem_req) begin
                seen_nf = 1;
                if (src1 !== word[8:6] || src2 !== word[5:3] || dst !== word[11:9] ||
                    imm !== word[7:0] || alu_op !== op) field_bad = 1;
            end
            if (wr_dst) wr_n++;
            if (rf_en) begin rf_n++; rf_cyc = cyc; end
            if (movil) ml_n++;
            if (movih) mh_n++;
            if (dmem_rd) rd_n++;
            if (dmem_wr) st_n++;
            if (imem_req) begin
                imem_valid = (fc == fwait);
                imem_data  = (fc == fwait) ? word : 16'($urandom);
                fc++;
            end else begin
                imem_valid = noise ? 1'($urandom) : 1'b0;
                imem_data  = 16'($urandom);
            end
            if (dmem_rd || dmem_wr) begin
                dmem_valid = (mc == mwait);
                mc++;
            end else begin
                dmem_valid = noise ? 1'($urandom) : 1'b0;
            end
            tick();
        end
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        if (op != 4'hF) pc_m = (pc_m + 1) % 256;

        total++;
        if (done !== 1'b1) $display("FAIL %h timeout: no return to fetch within 80 cycles", word);
        else passed++;
        total++;
        if (total_c !== exp_total) $display("FAIL %h latency: got %0d want %0d", word, total_c, exp_total);
        else passed++;
        total++;
        if (field_bad !== 1'b0) $display("FAIL %h fields: unstable or wrong decode outputs (got 1 want 0)", word);
        else passed++;
        total++;
        if (wr_n !== int'(exp_wr)) $display("FAIL %h wr_dest_count: got %0d want %0d", word, wr_n, exp_wr);
        else passed++;
        total++;
        if (rf_n !== int'(exp_rf)) $display("FAIL %h rf_en_count: got %0d want %0d", word, rf_n, exp_rf);
        else passed++;
        total++;
        if (rf_cyc !== exp_rf_cyc) $display("FAIL %h rf_en_cycle: got %0d want %0d", word, rf_cyc, exp_rf_cyc);
        else passed++;
        total++;
        if (ml_n !== int'(op == 4'hB) || mh_n !== int'(op == 4'hC))
            $display("FAIL %h movi_counts: got %0d/%0d want %0d/%0d", word, ml_n, mh_n, op == 4'hB, op == 4'hC);
        else passed++;
        total++;
        if (rd_n !== ((op == 4'hD) ? mwait + 1 : 0) || st_n !== ((op == 4'hE) ? mwait + 1 : 0))
            $display("FAIL %h dmem_counts: got rd %0d wr %0d want wait %0d", word, rd_n, st_n, mwait);
        else passed++;
        total++;
        if (halted !== (op == 4'hF)) $display("FAIL %h halted: got %b want %b", word, halted, op == 4'hF);
        else passed++;
        total++;
        if (pc !== 8'(pc_m)) $display("FAIL %h pc: got %0d want %0d", word, pc, pc_m);
        else passed++;
    endtask

    task automatic check_reset_state(input string tag);
        total++;
        if (imem_req !== 1'b1 || pc !== 8'd0 || halted !== 1'b0 || wr_dst !== 1'b0 ||
            rf_en !== 1'b0 || movil !== 1'b0 || movih !== 1'b0 || dmem_rd !== 1'b0 ||
            dmem_wr !== 1'b0)
            $display("FAIL %s reset_ctrl: got req=%b pc=%0d halted=%b strobes=%b%b%b%b%b%b want req=1 pc=0 rest 0",
                     tag, imem_req, pc, halted, wr_dst, rf_en, movil, movih, dmem_rd, dmem_wr);
        else passed++;
        total++;
        if ({src1, src2, dst, imm, alu_op} !== 21'd0)
            $display("FAIL %s reset_fields: got %h want 0", tag, {src1, src2, dst, imm, alu_op});
        else passed++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        check_reset_state("power_on");
        reset_n = 1'b1;
        pc_m = 0;
    endtask

    task automatic test_add();
        run_instr(16'h1650, 0, 0, 0);
    endtask

    task automatic test_movi();
        run_instr(16'hBAA5, 0, 0, 0);
        run_instr(16'hCA5A, 0, 0, 0);
    endtask

    task automatic test_load_store();
        run_instr(16'hD400, 0, 3, 0);
        run_instr(16'hE400, 1, 2, 0);
    endtask

    task automatic test_clk_en();
        bit found = 0;
        imem_valid = 1'b1;
        imem_data  = 16'h2A8B;
        for (int i = 0; i < 10; i++) begin
            tick();
            imem_valid = 1'b0;
            if (rf_en) begin found = 1; break; end
        end
        total++;
        if (found !== 1'b1) $display("FAIL clk_en_reach_wb: got 0 want 1");
        else passed++;
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (wr_dst !== 1'b1 || rf_en !== 1'b1 || pc !== 8'(pc_m))
                $display("FAIL clk_en_hold: got wr=%b rf=%b pc=%0d want 1 1 %0d", wr_dst, rf_en, pc, pc_m);
            else passed++;
        end
        clk_en = 1'b1;
        pc_m = (pc_m + 1) % 256;
        tick();
        total++;
        if (wr_dst !== 1'b0 || rf_en !== 1'b0 || imem_req !== 1'b1 || pc !== 8'(pc_m))
            $display("FAIL clk_en_resume: got wr=%b rf=%b req=%b pc=%0d want 0 0 1 %0d",
                     wr_dst, rf_en, imem_req, pc, pc_m);
        else passed++;
        tick();
        total++;
        if (pc !== 8'(pc_m)) $display("FAIL clk_en_single_inc: got %0d want %0d", pc, pc_m);
        else passed++;
    endtask

    task automatic test_random();
        logic [15:0] w;
        for (int i = 0; i < 40; i++) begin
            w = {4'($urandom_range(0, 14)), 12'($urandom)};
            run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
        end
    endtask

    task automatic test_wrap();
        while (pc_m != 255) run_instr(16'h0000, 0, 0, 0);
        total++;
        if (pc !== 8'd255) $display("FAIL wrap_at_255: got %0d want 255", pc);
        else passed++;
        run_instr(16'h0123, 0, 0, 1'b1);
    endtask

    task automatic test_halt();
        run_instr(16'hF000, 1, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            imem_valid = 1'($urandom);
            dmem_valid = 1'($urandom);
            imem_data  = 16'($urandom);
            tick();
            total++;
            if (halted !== 1'b1 || imem_req !== 1'b0 || rf_en !== 1'b0 || dmem_rd !== 1'b0 ||
                dmem_wr !== 1'b0)
                $display("FAIL halt_sticky: got halted=%b req=%b rf=%b want 1 0 0", halted, imem_req, rf_en);
            else passed++;
        end
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
    endtask

    task automatic test_reset_midrun();
        #3;
        reset_n = 1'b0;
        tick();
        check_reset_state("midrun");
        reset_n = 1'b1;
        pc_m = 0;
        run_instr(16'h7123, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_movi();
        test_load_store();
        test_clk_en();
        test_random();
        test_wrap();
        test_halt();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
